shell_ctrl: RTL
===============

# shell_ctrl

Ballistic shell controller for one tank. It sits directly downstream of the tank controller and consumes the tank's `shoot` pulse, position, `Direction` and `y_component` elevation. On each fire event it launches one shell and integrates its flight under gravity, one step per frame. It terminates the flight on target hit, ground or screen edge, then holds an explosion phase for a fixed number of frames. Its outputs feed the colour mapper and the score/hit logic.

## Interface
Parameters:
- `VX`, 2: horizontal speed, pixels/frame.
- `VY_MAX`, 15: clamp for the initial upward speed.
- `GRAV_DIV`, 4: frames per 1-pixel/frame decrement of vertical speed. Must be ≥ 1.
- `GROUND_Y`, 479: ground line; largest legal shell Y.
- `X_MIN`, 0 / `X_MAX`, 639: horizontal screen limits.
- `SHELL_SIZE`, 2: shell half-size.
- `EXPLODE_FRAMES`, 16: length of the explosion phase, in frames.

Ports:
- `frame_clk`, in, 1: the single clock, one edge per video frame.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `shoot`, in, 1: fire request, sampled on each clock edge.
- `TankX`, `TankY`, in, 10 each: launch point.
- `Direction`, in, 2: bit0 = 1 fires right (+VX); bit0 = 0 fires left (−VX).
- `y_component`, in, 10: unsigned initial upward speed.
- `TargetX`, `TargetY`, `TargetS`, in, 10 each: opposing tank centre and half-size.
- `ShellX`, `ShellY`, `ShellS`, out, 10 each: shell centre and size. `ShellS` is constant `SHELL_SIZE`.
- `shell_active`, out, 1: shell is in flight.
- `exploding`, out, 1: explosion phase is in progress.
- `hit`, out, 1: one-cycle pulse when the flight ends on the target.
- `busy`, out, 1: `shell_active | exploding`.

## Operation
- FSM states: IDLE, FLIGHT, EXPLODE.
- IDLE + `shoot`=1:
  - `ShellX`←`TankX`, `ShellY`←`TankY`.
  - `vx`←±`VX`.
  - `vy`←min(`y_component`, `VY_MAX`).
  - `gcnt`←0.
  - Next state FLIGHT.
- `shoot` outside IDLE is ignored; no queuing.
- Each FLIGHT cycle:
  - nx = x+vx, ny = y−vy, computed 12-bit signed.
  - vy' = vy−1 if `gcnt`==`GRAV_DIV`−1, else vy.
  - `gcnt` wraps modulo `GRAV_DIV`.
  - vy is 8-bit signed and saturates at −128.
- Termination checks on (nx, ny), in priority order:
  1. Hit: |nx−`TargetX`| ≤ `TargetS`+`SHELL_SIZE` and |ny−`TargetY`| ≤ `TargetS`+`SHELL_SIZE`. Go to EXPLODE at (nx, ny) and pulse `hit`.
  2. Ground: ny ≥ `GROUND_Y`. Go to EXPLODE at (nx, `GROUND_Y`).
  3. Wall: nx < `X_MIN` or nx > `X_MAX`. Go to EXPLODE with x clamped to the violated limit, y = ny.
  4. Top edge: ny < 0 is legal. Internal Y is kept signed. Output `ShellY` = 0 while internal Y < 0.
  5. Otherwise remain in FLIGHT and commit (nx, ny, vy').
- EXPLODE:
  - Position frozen.
  - Counter runs 0..`EXPLODE_FRAMES`−1.
  - On the last count, go to IDLE.
  - `shoot` on that final cycle is ignored. The first frame a new shot is accepted is the first IDLE cycle.
- Reset (any state, asynchronous assert):
  - State IDLE.
  - `ShellX`=0, `ShellY`=0.
  - `shell_active`=0, `exploding`=0, `hit`=0, `busy`=0.
  - Counters 0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Launch latency: `shoot` sampled at edge N → `shell_active`=1 and shell at the tank position after edge N. The first movement appears after edge N+1.
- `hit` is high for exactly the one cycle in which `exploding` first rises.
- The explosion lasts exactly `EXPLODE_FRAMES` cycles of `exploding`=1.
- `shoot` is level-sampled. The upstream one-shot logic guarantees single pulses; a held `shoot` refires on the first IDLE cycle.
- Reset deassertion is synchronised by the top level. The block assumes release is clean relative to `frame_clk`.

## Structure
- Shared package `tank_pkg`:
  - `shell_state_t` enum (IDLE/FLIGHT/EXPLODE).
  - Screen constants `SCREEN_W`=640, `SCREEN_H`=480.
  - Direction encoding constants `DIR_LEFT`=0, `DIR_RIGHT`=1.
- One sub-module, `shell_physics`: purely combinational.
  - Inputs: x, y, vx, vy, gcnt, target.
  - Outputs: nx, ny, vy', hit/ground/wall flags.
- The FSM, counters and output registers stay in `shell_ctrl`.

## Test plan
- Reset: assert `Reset_n`=0 mid-FLIGHT → all outputs 0 immediately, without waiting for a clock edge. After release, state is IDLE and the next `shoot` is accepted.
- Flat shot: TankX=500, TankY=200, Direction=1, y_component=0, shoot for 1 frame.
  - After launch edge: (500,200).
  - Next 4 frames: x = 502, 504, 506, 508; y = 200 each.
  - 5th frame: (510,201).
- Clamp: y_component=300 → first move y decreases by 15. After 4 FLIGHT frames the per-frame step becomes 14.
- Wall: Direction=1, TankX=636, y_component=0.
  - Frame 1: x=638.
  - Frame 2: `exploding`=1 with `ShellX`=639, `hit`=0.
  - `exploding` lasts exactly 16 frames, then IDLE.
- Hit and lockout:
  - Setup: TargetX=510, TargetY=200, TargetS=4, shot from (500,200) rightward with y_component=0.
  - Hit when nx=504 (|504−510| = 6 ≤ 6): `hit` pulses at (504,200).
  - `shoot` pulses during FLIGHT and during every EXPLODE frame → no relaunch.
- Ground: TankY=470, Direction=0, y_component=0, GRAV_DIV=4 → shell falls. EXPLODE is entered with `ShellY`=479 exactly.

Source files
------------

// File: rtl/tank_pkg.sv
// Types and screen constants shared by the tank game blocks.
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLIGHT  = 2'd1,
        EXPLODE = 2'd2
    } shell_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shell_physics.sv
// One frame of shell motion under gravity plus the collision tests on the
// candidate position. Purely combinational; the controller owns all state.
module shell_physics
    import tank_pkg::*;
#(
    parameter int GRAV_DIV   = 4,
    parameter int GROUND_Y   = SCREEN_H - 1,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = SCREEN_W - 1,
    parameter int SHELL_SIZE = 2,
    parameter int GCNT_W     = 2
) (
    input  logic signed [11:0] x,
    input  logic signed [11:0] y,
    input  logic signed [11:0] vx,
    input  logic signed [7:0]  vy,
    input  logic [GCNT_W-1:0]  gcnt,
    input  logic [9:0]         target_x,
    input  logic [9:0]         target_y,
    input  logic [9:0]         target_s,
    output logic signed [11:0] nx,
    output logic signed [11:0] ny,
    output logic signed [7:0]  vy_next,
    output logic               hit,
    output logic               ground,
    output logic               wall_lo,
    output logic               wall_hi
);

    localparam logic [GCNT_W-1:0]  GCNT_LAST = GCNT_W'(GRAV_DIV - 1);
    localparam logic signed [11:0] GROUND_S  = 12'(GROUND_Y);
    localparam logic signed [11:0] X_LO_S    = 12'(X_MIN);
    localparam logic signed [11:0] X_HI_S    = 12'(X_MAX);
    localparam logic signed [12:0] PAD_S     = 13'(SHELL_SIZE);

    // Vertical speed never wraps past its most negative value.
    function automatic logic signed [7:0] dec_sat(input logic signed [7:0] v);
        return (v == 8'sh80) ? v : v - 8'sd1;
    endfunction

    function automatic logic signed [12:0] abs13(input logic signed [12:0] v);
        return (v < 0) ? -v : v;
    endfunction

    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic signed [12:0] reach;

    // Advance the shell one frame and test the new point against target, ground and walls.
    always_comb begin
        nx      = x + vx;
        ny      = y - $signed({{4{vy[7]}}, vy});
        vy_next = (gcnt == GCNT_LAST) ? dec_sat(vy) : vy;
        dx      = $signed({nx[11], nx}) - $signed({3'b000, target_x});
        dy      = $signed({ny[11], ny}) - $signed({3'b000, target_y});
        reach   = $signed({3'b000, target_s}) + PAD_S;
        hit     = (abs13(dx) <= reach) && (abs13(dy) <= reach);
        ground  = (ny >= GROUND_S);
        wall_lo = (nx < X_LO_S);
        wall_hi = (nx > X_HI_S);
    end

endmodule

// File: rtl/shell_ctrl.sv
// Ballistic shell controller: launches one shell per fire request, flies it
// frame by frame, and holds a fixed-length explosion when the flight ends.
module shell_ctrl
    import tank_pkg::*;
#(
    parameter int VX             = 2,
    parameter int VY_MAX         = 15,
    parameter int GRAV_DIV       = 4,
    parameter int GROUND_Y       = SCREEN_H - 1,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = SCREEN_W - 1,
    parameter int SHELL_SIZE     = 2,
    parameter int EXPLODE_FRAMES = 16
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       shoot,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] Direction,
    input  logic [9:0] y_component,
    input  logic [9:0] TargetX,
    input  logic [9:0] TargetY,
    input  logic [9:0] TargetS,
    output logic [9:0] ShellX,
    output logic [9:0] ShellY,
    output logic [9:0] ShellS,
    output logic       shell_active,
    output logic       exploding,
    output logic       hit,
    output logic       busy
);

    localparam int GCNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam int ECNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

    localparam logic [GCNT_W-1:0]  GCNT_LAST = GCNT_W'(GRAV_DIV - 1);
    localparam logic [ECNT_W-1:0]  ECNT_LAST = ECNT_W'(EXPLODE_FRAMES - 1);
    localparam logic signed [11:0] VX_S      = 12'(VX);
    localparam logic [9:0]         VY_CLAMP  = 10'(VY_MAX);
    localparam logic signed [11:0] GROUND_S  = 12'(GROUND_Y);
    localparam logic signed [11:0] X_LO_S    = 12'(X_MIN);
    localparam logic signed [11:0] X_HI_S    = 12'(X_MAX);

    // The shell may sit above the top edge; the screen only ever shows row 0 there.
    function automatic logic [9:0] to_screen_y(input logic signed [11:0] v);
        return (v < 0) ? 10'd0 : v[9:0];
    endfunction

    // A terminating point can lie just past a wall; rest it on the screen.
    function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
        if (v < X_LO_S) return X_LO_S[9:0];
        if (v > X_HI_S) return X_HI_S[9:0];
        return v[9:0];
    endfunction

    shell_state_t       state;
    logic signed [11:0] y;
    logic signed [11:0] vx;
    logic signed [7:0]  vy;
    logic [GCNT_W-1:0]  gcnt;
    logic [ECNT_W-1:0]  ecnt;

    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic signed [7:0]  vy_next;
    logic               p_hit;
    logic               p_ground;
    logic               p_wall_lo;
    logic               p_wall_hi;

    logic [9:0]         vy_launch;
    logic [9:0]         land_x;
    logic signed [11:0] land_y;
    logic               term;
    logic               unused_dir;

    assign ShellS     = 10'(SHELL_SIZE);
    assign vy_launch  = (y_component > VY_CLAMP) ? VY_CLAMP : y_component;
    assign unused_dir = Direction[1];

    shell_physics #(
        .GRAV_DIV   (GRAV_DIV),
        .GROUND_Y   (GROUND_Y),
        .X_MIN      (X_MIN),
        .X_MAX      (X_MAX),
        .SHELL_SIZE (SHELL_SIZE),
        .GCNT_W     (GCNT_W)
    ) u_physics (
        .x        ($signed({2'b00, ShellX})),
        .y        (y),
        .vx       (vx),
        .vy       (vy),
        .gcnt     (gcnt),
        .target_x (TargetX),
        .target_y (TargetY),
        .target_s (TargetS),
        .nx       (nx),
        .ny       (ny),
        .vy_next  (vy_next),
        .hit      (p_hit),
        .ground   (p_ground),
        .wall_lo  (p_wall_lo),
        .wall_hi  (p_wall_hi)
    );

    // Decide whether this frame ends the flight and where the shell comes to rest.
    always_comb begin
        term   = p_hit | p_ground | p_wall_lo | p_wall_hi;
        land_x = clamp_x(nx);
        land_y = (!p_hit && p_ground) ? GROUND_S : ny;
    end

    // Shell FSM with registered position, phase flags and counters.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            ShellX       <= '0;
            ShellY       <= '0;
            y            <= '0;
            vx           <= '0;
            vy           <= '0;
            gcnt         <= '0;
            ecnt         <= '0;
            shell_active <= 1'b0;
            exploding    <= 1'b0;
            hit          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (shoot) begin
                        ShellX       <= TankX;
                        ShellY       <= TankY;
                        y            <= $signed({2'b00, TankY});
                        vx           <= (Direction[0] == DIR_RIGHT) ? VX_S : -VX_S;
                        vy           <= $signed(vy_launch[7:0]);
                        gcnt         <= '0;
                        shell_active <= 1'b1;
                        busy         <= 1'b1;
                        state        <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    gcnt   <= (gcnt == GCNT_LAST) ? '0 : gcnt + 1'b1;
                    vy     <= vy_next;
                    ShellX <= land_x;
                    y      <= land_y;
                    ShellY <= to_screen_y(land_y);
                    if (term) begin
                        shell_active <= 1'b0;
                        exploding    <= 1'b1;
                        hit          <= p_hit;
                        ecnt         <= '0;
                        state        <= EXPLODE;
                    end
                end
                EXPLODE: begin
                    if (ecnt == ECNT_LAST) begin
                        ecnt      <= '0;
                        exploding <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        ecnt <= ecnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
